// File: rtl/fdct_butterfly_stage_pkg.sv
// Shared defaults and types for the FDCT butterfly stage.
package fdct_pkg;

    localparam int FDCT_WIDTH_IN  = 8;
    localparam int FDCT_WIDTH_OUT = 9;
    localparam int FDCT_N         = 8;

    // Width of a counter that spans 0..n-1 (never narrower than one bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int FDCT_CNT_W = cnt_width(FDCT_N);

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } bfly_state_t;

endpackage

// File: rtl/fdct_butterfly_stage_butterfly_unit.sv
// Combinational butterfly: sign-extends both operands by the output width
// and produces their exact sum and difference.
module butterfly_unit
    import fdct_pkg::*;
#(
    parameter int WIDTH_IN  = FDCT_WIDTH_IN,
    parameter int WIDTH_OUT = FDCT_WIDTH_OUT
) (
    input  logic signed [WIDTH_IN-1:0]  a,
    input  logic signed [WIDTH_IN-1:0]  b,
    output logic signed [WIDTH_OUT-1:0] sum,
    output logic signed [WIDTH_OUT-1:0] diff
);

    logic [WIDTH_OUT-1:0] a_ext;
    logic [WIDTH_OUT-1:0] b_ext;

    // Sign-extend first so the one extra output bit absorbs any carry.
    always_comb begin
        a_ext = {{(WIDTH_OUT-WIDTH_IN){a[WIDTH_IN-1]}}, a};
        b_ext = {{(WIDTH_OUT-WIDTH_IN){b[WIDTH_IN-1]}}, b};
        sum   = a_ext + b_ext;
        diff  = a_ext - b_ext;
    end

endmodule

// File: rtl/fdct_butterfly_stage.sv
// First FDCT stage: gathers a row of N samples, then streams the N/2
// butterfly sums followed by the N/2 butterfly differences.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; the producer holds its data stable while valid && !ready, and
// ready never depends on valid. Input side is open only in FILL, output side
// only in DRAIN, so the two never transfer in the same cycle.
module fdct_butterfly_stage
    import fdct_pkg::*;
#(
    parameter int WIDTH_IN  = FDCT_WIDTH_IN,
    parameter int WIDTH_OUT = FDCT_WIDTH_OUT,
    parameter int N         = FDCT_N
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH_IN-1:0]    in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH_OUT-1:0]   out_data,
    output logic [$clog2(N)-1:0]   out_idx,
    output logic                   out_last
);

    localparam int            CW   = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    // state and cnt are the observable FSM context (FILL/DRAIN, position in row).
    bfly_state_t                state;
    logic [CW-1:0]              cnt;
    logic signed [WIDTH_IN-1:0] x [N];

    logic                        accept;
    logic                        handshake;
    logic                        cnt_last;
    logic [CW-1:0]               i_idx;
    logic [CW-1:0]               j_idx;
    logic signed [WIDTH_IN-1:0]  op_a;
    logic signed [WIDTH_IN-1:0]  op_b;
    logic signed [WIDTH_OUT-1:0] bf_sum;
    logic signed [WIDTH_OUT-1:0] bf_diff;

    assign cnt_last  = (cnt == LAST);
    assign in_ready  = (state == FILL) && !reset;
    assign out_valid = (state == DRAIN) && !reset;
    assign accept    = in_valid && in_ready;
    assign handshake = out_valid && out_ready;

    // Control FSM: count accepts in FILL, count handshakes in DRAIN.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FILL;
            cnt   <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        if (cnt_last) begin
                            cnt   <= '0;
                            state <= DRAIN;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (handshake) begin
                        if (cnt_last) begin
                            cnt   <= '0;
                            state <= FILL;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= FILL;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Sample store: written only on an accepted input, never reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            x[cnt] <= in_data;
        end
    end

    // Pair selection: the MSB of cnt picks sum vs diff; the low bits give i,
    // and the mirror partner is N-1-i. N is a power of two here.
    always_comb begin
        i_idx         = cnt;
        i_idx[CW-1]   = 1'b0;
        j_idx         = LAST - i_idx;
        op_a          = x[i_idx];
        op_b          = x[j_idx];
    end

    butterfly_unit #(
        .WIDTH_IN  (WIDTH_IN),
        .WIDTH_OUT (WIDTH_OUT)
    ) u_bfly (
        .a    (op_a),
        .b    (op_b),
        .sum  (bf_sum),
        .diff (bf_diff)
    );

    // Output mux: results come from registered samples and count, zero when idle.
    always_comb begin
        out_data = '0;
        out_idx  = '0;
        out_last = 1'b0;
        if (out_valid) begin
            out_data = cnt[CW-1] ? bf_diff : bf_sum;
            out_idx  = cnt;
            out_last = cnt_last;
        end
    end

endmodule

// File: tb/tb_fdct_butterfly_stage.sv
// Directed bench for fdct_butterfly_stage with hand-computed row results.
module tb_fdct_butterfly_stage;

    typedef logic [7:0] row_t [8];
    typedef logic [8:0] res_t [8];

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] out_data;
    logic [2:0] out_idx;
    logic       out_last;

    always #5 clk = ~clk;

    fdct_butterfly_stage #(
        .WIDTH_IN  (8),
        .WIDTH_OUT (9),
        .N         (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    // ---------------- scoreboard ----------------
    logic [8:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic load_exp(input res_t r);
        for (int i = 0; i < 8; i++) exp_q.push_back(r[i]);
    endtask

    // ---------------- driver tasks ----------------
    // Offer nsamp samples; with gaps, an idle cycle carrying junk data
    // precedes every sample.
    task automatic send_row(input row_t row, input int nsamp, input bit gaps);
        for (int k = 0; k < nsamp; k++) begin
            if (gaps) begin
                in_valid = 1'b0;
                in_data  = 8'hAA;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = row[k];
            check("in_ready_fill", in_ready, 1);
            check("out_valid_fill", out_valid, 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    // Consume nres results; optionally stall at one index and poke input.
    task automatic drain_row(input int nres, input int stall_at, input int stall_len, input bit poke);
        for (int i = 0; i < nres; i++) begin
            logic [8:0] e;
            e = exp_q.pop_front();
            if (poke) begin
                in_valid = 1'b1;
                in_data  = 8'd99;
            end
            if (i == stall_at) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    check("stall_valid", out_valid, 1);
                    check("stall_idx", out_idx, i);
                    check("stall_data", out_data, e);
                    @(posedge clk); #1;
                end
            end
            out_ready = 1'b1;
            check("out_valid", out_valid, 1);
            check("out_idx", out_idx, i);
            check("out_data", out_data, e);
            check("out_last", out_last, (i == 7) ? 1 : 0);
            check("in_ready_drain", in_ready, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
    endtask

    task automatic pulse_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        reset     = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_out_valid", out_valid, 0);
        check("post_rst_out_idx", out_idx, 0);
        exp_q.delete();
    endtask

    // ---------------- stimulus ----------------
    row_t ramp, ext, maxr, mix;
    res_t ramp_exp, ext_exp, max_exp, mix_exp;

    initial begin
        ramp     = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        ramp_exp = '{9'h007, 9'h007, 9'h007, 9'h007, 9'h1F9, 9'h1FB, 9'h1FD, 9'h1FF};
        ext      = '{8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h7F};
        ext_exp  = '{9'h1FF, 9'h000, 9'h000, 9'h000, 9'h101, 9'h000, 9'h000, 9'h000};
        maxr     = '{8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F};
        max_exp  = '{9'h0FE, 9'h0FE, 9'h0FE, 9'h0FE, 9'h000, 9'h000, 9'h000, 9'h000};
        // 10,-20,30,-40,50,-60,70,-80
        mix      = '{8'h0A, 8'hEC, 8'h1E, 8'hD8, 8'h32, 8'hC4, 8'h46, 8'hB0};
        // sums -70,50,-30,10 ; diffs 90,-90,90,-90
        mix_exp  = '{9'h1BA, 9'h032, 9'h1E2, 9'h00A, 9'h05A, 9'h1A6, 9'h05A, 9'h1A6};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", in_ready, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_out_idx", out_idx, 0);
        check("reset_out_last", out_last, 0);
        reset = 1'b0;
        #1;
        check("first_fill_in_ready", in_ready, 1);

        // Ramp, then extremes and all-max back to back.
        load_exp(ramp_exp); send_row(ramp, 8, 1'b0); drain_row(8, -1, 0, 1'b0);
        load_exp(ext_exp);  send_row(ext, 8, 1'b0);  drain_row(8, -1, 0, 1'b0);
        // Input poked with 99 during drain must be ignored.
        load_exp(max_exp);  send_row(maxr, 8, 1'b0); drain_row(8, -1, 0, 1'b1);

        // Backpressure: 3 stalled cycles at index 2.
        load_exp(ramp_exp); send_row(ramp, 8, 1'b0); drain_row(8, 2, 3, 1'b0);

        // Gapped input.
        load_exp(mix_exp);  send_row(mix, 8, 1'b1);  drain_row(8, -1, 0, 1'b0);

        // Reset after 5 accepts, then a clean ramp.
        send_row(mix, 5, 1'b0);
        pulse_reset();
        load_exp(ramp_exp); send_row(ramp, 8, 1'b0); drain_row(8, -1, 0, 1'b0);

        // Reset while out_idx = 4, then a clean ramp.
        load_exp(max_exp);  send_row(maxr, 8, 1'b0); drain_row(4, -1, 0, 1'b0);
        check("mid_drain_idx", out_idx, 4);
        pulse_reset();
        load_exp(ramp_exp); send_row(ramp, 8, 1'b0); drain_row(8, -1, 0, 1'b0);
        check("final_in_ready", in_ready, 1);

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
